// File: rtl/event_metadata_parser.sv
// UniMon event metadata parser: pulls event records out of metadata word 1
// into a FWFT event FIFO and forwards data packets with 2-cycle latency.
module event_metadata_parser #(
    parameter int          w_meta   = 134,
    parameter int          w_info   = 32,
    parameter int          w_evb    = 8,
    parameter int          w_tmp    = 8,
    parameter int          d_evFifo = 4,
    parameter logic [7:0]  TIME_OUT = 8'd8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           metadata_in_valid,
    input  logic [w_meta-1:0]              metadata_in,
    output logic                           metadata_out_valid,
    output logic [w_meta-1:0]              metadata_out,
    output logic                           event_valid,
    output logic [w_info+w_evb+w_tmp:0]    event_data,
    input  logic                           event_ready,
    output logic [31:0]                    cnt_event,
    output logic [31:0]                    cnt_drop,
    output logic [31:0]                    cnt_err
);

    localparam int lo_tmp  = 72;
    localparam int lo_evb  = lo_tmp + w_tmp;
    localparam int lo_info = lo_evb + w_evb;
    localparam int w_rec   = 1 + w_info + w_evb + w_tmp;
    localparam int depth   = 1 << d_evFifo;

    localparam logic [d_evFifo:0]   cnt_one = 1;
    localparam logic [d_evFifo:0]   cnt_max = depth[d_evFifo:0];
    localparam logic [d_evFifo-1:0] ptr_one = 1;

    typedef enum logic [1:0] {IDLE, WORD1, BODY} state_t;

    state_t state, nstate;

    logic [1:0]        tag;
    logic              head, tail, aging;
    logic [w_meta-1:0] s1_data;
    logic              s1_ok, s1_ok_n;
    logic              rel, push, err;
    logic [w_rec-1:0]  rec;

    assign tag   = metadata_in[w_meta-1 -: 2];
    assign head  = metadata_in_valid && (tag == 2'b01);
    assign tail  = (tag == 2'b10);
    assign aging = tail && (metadata_in[lo_info +: 8] == TIME_OUT);
    assign rec   = {aging, metadata_in[lo_info +: w_info],
                    metadata_in[lo_evb +: w_evb], metadata_in[lo_tmp +: w_tmp]};

    // s1 holds the word one cycle old; rel releases it to the output stage.
    // Word 0 stays unreleased until word 1 shows whether the packet is aging.
    always_comb begin
        nstate  = state;
        s1_ok_n = 1'b0;
        rel     = 1'b0;
        push    = 1'b0;
        err     = 1'b0;
        unique case (state)
            IDLE: begin
                rel = s1_ok;
                if (metadata_in_valid) begin
                    if (head) nstate = WORD1;
                    else      err    = 1'b1;
                end
            end
            WORD1: begin
                if (!metadata_in_valid) begin
                    err    = 1'b1;
                    nstate = IDLE;
                end else if (head) begin
                    err = 1'b1;
                end else begin
                    push    = 1'b1;
                    rel     = !aging;
                    s1_ok_n = !aging;
                    nstate  = tail ? IDLE : BODY;
                end
            end
            BODY: begin
                if (!metadata_in_valid) begin
                    err    = 1'b1;
                    nstate = IDLE;
                end else if (head) begin
                    err    = 1'b1;
                    nstate = WORD1;
                end else begin
                    rel     = s1_ok;
                    s1_ok_n = 1'b1;
                    nstate  = tail ? IDLE : BODY;
                end
            end
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state              <= IDLE;
            s1_data            <= '0;
            s1_ok              <= 1'b0;
            metadata_out_valid <= 1'b0;
            metadata_out       <= '0;
        end else begin
            state              <= nstate;
            s1_ok              <= s1_ok_n;
            metadata_out_valid <= rel;
            if (metadata_in_valid) s1_data <= metadata_in;
            if (rel) metadata_out <= s1_data;
        end
    end

    logic [w_rec-1:0]    mem [depth];
    logic [d_evFifo-1:0] wr_ptr, rd_ptr;
    logic [d_evFifo:0]   count;
    logic                full, pop, accept, drop;

    assign full        = (count == cnt_max);
    assign event_valid = (count != '0);
    assign pop         = event_valid && event_ready;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign accept      = push && (!full || pop);
    assign drop        = push && full && !pop;
    assign event_data  = event_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= rec;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            cnt_event <= '0;
            cnt_drop  <= '0;
            cnt_err   <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + ptr_one;
            if (pop)    rd_ptr <= rd_ptr + ptr_one;
            unique case ({accept, pop})
                2'b10:   count <= count + cnt_one;
                2'b01:   count <= count - cnt_one;
                default: count <= count;
            endcase
            if (accept) cnt_event <= cnt_event + 32'd1;
            if (drop)   cnt_drop  <= cnt_drop + 32'd1;
            if (err)    cnt_err   <= cnt_err + 32'd1;
        end
    end

endmodule

// File: tb/tb_event_metadata_parser.sv
// Directed bench for event_metadata_parser: forwarding latency, records,
// FIFO full/drop, framing errors and mid-packet reset.
module tb_event_metadata_parser;

    logic         clk;
    logic         reset;
    logic         metadata_in_valid;
    logic [133:0] metadata_in;
    logic         metadata_out_valid;
    logic [133:0] metadata_out;
    logic         event_valid;
    logic [48:0]  event_data;
    logic         event_ready;
    logic [31:0]  cnt_event, cnt_drop, cnt_err;

    int checks = 0;
    int errors = 0;

    event_metadata_parser dut (
        .clk(clk),
        .reset(reset),
        .metadata_in_valid(metadata_in_valid),
        .metadata_in(metadata_in),
        .metadata_out_valid(metadata_out_valid),
        .metadata_out(metadata_out),
        .event_valid(event_valid),
        .event_data(event_data),
        .event_ready(event_ready),
        .cnt_event(cnt_event),
        .cnt_drop(cnt_drop),
        .cnt_err(cnt_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [133:0] mk(input logic [1:0] tag,
                                        input logic [31:0] info,
                                        input logic [7:0] evb,
                                        input logic [7:0] tmp,
                                        input logic [71:0] fill);
        return {tag, 12'h0, info, evb, tmp, fill};
    endfunction

    function automatic logic [48:0] rc(input logic ag, input logic [31:0] info,
                                       input logic [7:0] evb, input logic [7:0] tmp);
        return {ag, info, evb, tmp};
    endfunction

    task automatic chk(input string tag, input logic [133:0] obs,
                       input logic [133:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [133:0] d);
        @(negedge clk);
        metadata_in_valid = v;
        metadata_in       = d;
    endtask

    logic [133:0] w0, w1, w2, w3, h, ag, a1, b1;
    logic [31:0]  info_q [16];

    initial begin
        reset = 1'b0;
        metadata_in_valid = 1'b0;
        metadata_in = '0;
        event_ready = 1'b0;
        #1;
        chk("rst_out_valid", metadata_out_valid, 0);
        chk("rst_out", metadata_out, 0);
        chk("rst_ev_valid", event_valid, 0);
        chk("rst_ev_data", event_data, 0);
        chk("rst_cnt_event", cnt_event, 0);
        chk("rst_cnt_drop", cnt_drop, 0);
        chk("rst_cnt_err", cnt_err, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // 4-word data packet
        w0 = mk(2'b01, 32'h0, 8'h0, 8'h0, 72'h1);
        w1 = mk(2'b00, 32'hA5A5_0001, 8'h03, 8'h10, 72'h2);
        w2 = mk(2'b00, 32'h0, 8'h0, 8'h0, 72'h3);
        w3 = mk(2'b10, 32'h0, 8'h0, 8'h0, 72'h4);
        drive(1, w0);
        drive(1, w1);
        drive(1, w2);
        chk("d4_w0_v", metadata_out_valid, 1);
        chk("d4_w0", metadata_out, w0);
        chk("d4_rec_v", event_valid, 1);
        chk("d4_rec", event_data, rc(0, 32'hA5A5_0001, 8'h03, 8'h10));
        drive(1, w3);
        chk("d4_w1", metadata_out, w1);
        drive(0, '0);
        chk("d4_w2", metadata_out, w2);
        drive(0, '0);
        chk("d4_w3_v", metadata_out_valid, 1);
        chk("d4_w3", metadata_out, w3);
        drive(0, '0);
        chk("d4_idle_v", metadata_out_valid, 0);
        chk("d4_cnt_event", cnt_event, 1);
        event_ready = 1'b1;
        drive(0, '0);
        event_ready = 1'b0;
        chk("d4_popped", event_valid, 0);

        // aging packet
        ag = {2'b10, 4'h0, 8'h0, 24'h123456, 8'd8, 8'h02, 8'h7F, 72'b0};
        drive(1, {2'b01, 132'b0});
        drive(1, ag);
        drive(0, '0);
        chk("ag_out_v0", metadata_out_valid, 0);
        chk("ag_rec_v", event_valid, 1);
        chk("ag_rec", event_data, rc(1, 32'h1234_5608, 8'h02, 8'h7F));
        drive(0, '0);
        chk("ag_out_v1", metadata_out_valid, 0);
        event_ready = 1'b1;
        drive(0, '0);
        event_ready = 1'b0;
        chk("ag_out_v2", metadata_out_valid, 0);
        chk("ag_popped", event_valid, 0);
        chk("ag_cnt_event", cnt_event, 2);

        // fill FIFO: 17 two-word packets, the 17th dropped
        for (int i = 0; i < 17; i++) begin
            drive(1, mk(2'b01, 32'h0, 8'h0, 8'h0, 72'h0));
            drive(1, mk(2'b10, {16'hBEEF, 8'(i), 8'h00}, 8'h0, 8'h0, 72'h0));
        end
        drive(0, '0);
        drive(0, '0);
        chk("full_cnt_event", cnt_event, 18);
        chk("full_cnt_drop", cnt_drop, 1);
        chk("full_head", event_data, rc(0, 32'hBEEF_0000, 8'h0, 8'h0));

        // push with simultaneous pop while full
        drive(1, mk(2'b01, 32'h0, 8'h0, 8'h0, 72'h0));
        drive(1, mk(2'b10, {16'hBEEF, 8'd17, 8'h00}, 8'h0, 8'h0, 72'h0));
        event_ready = 1'b1;
        drive(0, '0);
        chk("pp_cnt_event", cnt_event, 19);
        chk("pp_cnt_drop", cnt_drop, 1);
        for (int j = 0; j < 15; j++) info_q[j] = {16'hBEEF, 8'(j + 1), 8'h00};
        info_q[15] = {16'hBEEF, 8'd17, 8'h00};
        for (int j = 0; j < 16; j++) begin
            chk($sformatf("drain_v%0d", j), event_valid, 1);
            chk($sformatf("drain_d%0d", j), event_data, rc(0, info_q[j], 8'h0, 8'h0));
            @(negedge clk);
        end
        chk("drain_empty", event_valid, 0);
        event_ready = 1'b0;

        // framing 1: body word in IDLE
        chk("fr_err0", cnt_err, 0);
        drive(1, mk(2'b00, 32'h0, 8'h0, 8'h0, 72'h9));
        drive(0, '0);
        chk("fr1_out_v0", metadata_out_valid, 0);
        drive(0, '0);
        chk("fr1_out_v1", metadata_out_valid, 0);
        chk("fr1_err", cnt_err, 1);

        // framing 2: gap after word 0
        drive(1, mk(2'b01, 32'h0, 8'h0, 8'h0, 72'hA));
        drive(0, '0);
        drive(0, '0);
        chk("fr2_out_v0", metadata_out_valid, 0);
        chk("fr2_err", cnt_err, 2);
        drive(0, '0);
        chk("fr2_out_v1", metadata_out_valid, 0);
        chk("fr2_no_rec", event_valid, 0);

        // framing 3: new head in BODY, then a good 2-word packet
        h  = mk(2'b01, 32'h0, 8'h0, 8'h0, 72'hB0);
        a1 = mk(2'b00, 32'h1111_1111, 8'h01, 8'h01, 72'hB1);
        b1 = mk(2'b10, 32'h2222_0000, 8'h02, 8'h02, 72'hB3);
        drive(1, h);
        drive(1, a1);
        drive(1, mk(2'b00, 32'h0, 8'h0, 8'h0, 72'hB2));
        chk("fr3_a0", metadata_out, h);
        drive(1, {2'b01, 132'hC0});
        chk("fr3_a1", metadata_out, a1);
        drive(1, b1);
        drive(0, '0);
        chk("fr3_err", cnt_err, 3);
        chk("fr3_b0_v", metadata_out_valid, 1);
        chk("fr3_b0", metadata_out, {2'b01, 132'hC0});
        drive(0, '0);
        chk("fr3_b1_v", metadata_out_valid, 1);
        chk("fr3_b1", metadata_out, b1);
        drive(0, '0);
        chk("fr3_idle", metadata_out_valid, 0);
        chk("fr3_cnt_event", cnt_event, 21);
        chk("fr3_rec_a", event_data, rc(0, 32'h1111_1111, 8'h01, 8'h01));
        event_ready = 1'b1;
        @(negedge clk);
        chk("fr3_rec_b", event_data, rc(0, 32'h2222_0000, 8'h02, 8'h02));
        @(negedge clk);
        event_ready = 1'b0;
        chk("fr3_empty", event_valid, 0);

        // reset mid-packet
        drive(1, h);
        drive(1, a1);
        drive(1, mk(2'b00, 32'h0, 8'h0, 8'h0, 72'hD));
        chk("mr_out_v", metadata_out_valid, 1);
        #2;
        reset = 1'b0;
        metadata_in_valid = 1'b0;
        #1;
        chk("mr_out_valid", metadata_out_valid, 0);
        chk("mr_out", metadata_out, 0);
        chk("mr_ev_valid", event_valid, 0);
        chk("mr_ev_data", event_data, 0);
        chk("mr_cnt_event", cnt_event, 0);
        chk("mr_cnt_err", cnt_err, 0);
        chk("mr_cnt_drop", cnt_drop, 0);
        @(negedge clk);
        reset = 1'b1;
        w0 = mk(2'b01, 32'h0, 8'h0, 8'h0, 72'hE0);
        w1 = mk(2'b10, 32'h0BAD_F00D, 8'h5A, 8'hC3, 72'hE1);
        drive(1, w0);
        drive(1, w1);
        drive(0, '0);
        chk("mr_w0_v", metadata_out_valid, 1);
        chk("mr_w0", metadata_out, w0);
        chk("mr_rec", event_data, rc(0, 32'h0BAD_F00D, 8'h5A, 8'hC3));
        drive(0, '0);
        chk("mr_w1", metadata_out, w1);
        drive(0, '0);
        chk("mr_idle", metadata_out_valid, 0);
        chk("mr_cnt_event2", cnt_event, 1);
        chk("mr_cnt_err2", cnt_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
